// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings, state enumeration and helpers for the multicycle control unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
        S_MULT, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB, S_IACK, S_RFE
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_RFE   = 6'b010000;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;

    // Index of the lowest set bit; scanning downward lets the lowest index win.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ctrl_funct_dec.sv
// ctrl_funct_dec: R-type funct to ALU operation decode; alu_op flags functs that execute on the ALU.
module ctrl_funct_dec
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_op
);

    logic [3:0] op;

    always_comb begin
        op     = ALU_ADD;
        alu_op = 1'b1;
        case (funct)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            FN_SLL:  op = ALU_SLL;
            FN_SRL:  op = ALU_SRL;
            default: alu_op = 1'b0;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(op);

endmodule

// File: rtl/mc_controlunit.sv
// mc_controlunit: multicycle MIPS-style control FSM with multiplier wait and vectored interrupts.
// Outputs are Moore-decoded from the registered state; only BRANCH passes zero straight to pc_we.
module mc_controlunit
    import ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int NUM_IRQ     = 4,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic [NUM_IRQ-1:0]    irq,
    output logic                  pc_we,
    output logic                  ir_we,
    output logic                  iord,
    output logic                  we_reg,
    output logic                  we_dm,
    output logic                  reg_dst,
    output logic                  dm2reg,
    output logic                  alu_src_a,
    output logic                  jal,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  mult_start,
    output logic                  sf2reg,
    output logic                  sfmux_high,
    output logic                  iack,
    output logic [(NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1)-1:0] irq_id,
    output logic [1:0]            rfe,
    output logic                  illegal
);

    localparam int IDW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
    localparam logic [ALU_CTRL_W-1:0] A_ADD = ALU_CTRL_W'(ALU_ADD);
    localparam logic [ALU_CTRL_W-1:0] A_SUB = ALU_CTRL_W'(ALU_SUB);

    state_t               state_q, state_d, done_st;
    logic                 ie_q;
    logic [7:0]           cnt_q;
    logic [IDW-1:0]       id_q;
    logic [NUM_IRQ-1:0]   pend;
    logic [ALU_CTRL_W-1:0] fn_alu;
    logic                 fn_ok, is_mf, is_jr, is_mul;

    ctrl_funct_dec #(.ALU_CTRL_W(ALU_CTRL_W)) u_dec (
        .funct    (funct),
        .alu_ctrl (fn_alu),
        .alu_op   (fn_ok)
    );

    assign pend    = irq & {NUM_IRQ{ie_q}};
    assign done_st = |pend ? S_IACK : S_FETCH;
    assign is_mf   = funct == FN_MFHI || funct == FN_MFLO;
    assign is_jr   = funct == FN_JR;
    assign is_mul  = funct == FN_MULTU;

    // Every instruction end funnels through done_st, the single interrupt check point.
    always_comb begin
        state_d = done_st;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: case (opcode)
                OP_LW, OP_SW: state_d = S_MEMADR;
                OP_RTYPE:     state_d = S_EXEC;
                OP_BEQ:       state_d = S_BRANCH;
                OP_ADDI:      state_d = S_ADDIEX;
                OP_J, OP_JAL: state_d = S_JUMP;
                OP_RFE:       state_d = S_RFE;
                default:      state_d = done_st;
            endcase
            S_MEMADR: state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = is_mul ? S_MULT : (fn_ok || is_mf) ? S_ALUWB : done_st;
            S_MULT:   state_d = cnt_q == 8'd0 ? done_st : S_MULT;
            S_ADDIEX: state_d = S_ADDIWB;
            S_IACK:   state_d = S_FETCH;
            S_RFE:    state_d = S_FETCH;
            default:  state_d = done_st;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ie_q    <= 1'b1;
            cnt_q   <= 8'd0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IACK) ie_q <= 1'b0;
            else if (state_q == S_RFE) ie_q <= 1'b1;
            if (state_d == S_MULT && state_q != S_MULT) cnt_q <= 8'(MULT_CYCLES - 1);
            else if (state_q == S_MULT && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
            if (state_d == S_IACK) id_q <= IDW'(lowest_set(8'(pend)));
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        we_reg     = 1'b0;
        we_dm      = 1'b0;
        reg_dst    = 1'b0;
        dm2reg     = 1'b0;
        alu_src_a  = 1'b0;
        jal        = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = '0;
        mult_start = 1'b0;
        sf2reg     = 1'b0;
        sfmux_high = 1'b0;
        iack       = 1'b0;
        irq_id     = '0;
        rfe        = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = A_ADD;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = A_ADD;
                illegal   = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_JAL, OP_RFE});
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = A_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                we_reg = 1'b1;
                dm2reg = 1'b1;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                we_dm = 1'b1;
            end
            S_EXEC: begin
                alu_ctrl   = fn_alu;
                pc_src     = is_jr ? 2'b01 : 2'b00;
                pc_we      = is_jr;
                mult_start = is_mul;
                illegal    = !(fn_ok || is_mf || is_jr || is_mul);
            end
            S_ALUWB: begin
                we_reg     = 1'b1;
                reg_dst    = 1'b1;
                sf2reg     = is_mf;
                sfmux_high = funct == FN_MFHI;
            end
            S_BRANCH: begin
                alu_ctrl = A_SUB;
                pc_src   = 2'b01;
                pc_we    = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                jal    = opcode == OP_JAL;
                we_reg = opcode == OP_JAL;
            end
            S_ADDIWB: we_reg = 1'b1;
            S_IACK: begin
                iack   = 1'b1;
                irq_id = id_q;
                rfe    = 2'b10;
                pc_src = 2'b11;
                pc_we  = 1'b1;
            end
            S_RFE: begin
                rfe    = 2'b01;
                pc_src = 2'b11;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mc_controlunit.md
MC_CONTROLUNIT -- requirements
Module: mc_controlunit

Interface
REQ-001 Parameter MULT_CYCLES, default 4, multiplier busy cycles (range 1..255).
REQ-002 Parameter NUM_IRQ, default 4, interrupt request lines (range 1..8).
REQ-003 Parameter ALU_CTRL_W, default 4, width of alu_ctrl.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 opcode, funct  in  6 each  instruction fields; valid in DECODE and later states.
REQ-007 zero  in  1  ALU zero flag; used only in BRANCH.
REQ-008 irq  in  NUM_IRQ  level-sensitive interrupt requests.
REQ-009 pc_we, ir_we, iord, we_reg, we_dm, reg_dst, dm2reg, alu_src_a, jal  out  1 each  datapath enables and mux selects.
REQ-010 alu_src_b, pc_src  out  2 each  ALU B mux (00 reg, 01 const 4, 10 imm, 11 imm<<2); PC mux (00 ALU, 01 ALUout, 10 jump target, 11 vector/EPC).
REQ-011 alu_ctrl  out  ALU_CTRL_W  ALU operation.
REQ-012 mult_start, sf2reg, sfmux_high  out  1 each  multiplier start pulse, HI/LO writeback, HI select.
REQ-013 iack  out  1  interrupt acknowledge pulse; irq_id  out  max(1,clog2(NUM_IRQ))  acknowledged line.
REQ-014 rfe  out  2  01 = restore EPC to PC, 10 = save PC to EPC, 00 idle.
REQ-015 illegal  out  1  one-cycle pulse on unknown opcode/funct.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, MULT, BRANCH, JUMP, ADDIEX, ADDIWB, IACK, RFE.
REQ-017 FETCH: ir_we=1, pc_we=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00; -> DECODE.
REQ-018 Before FETCH is entered, if (irq & ie) is non-zero, state SHALL be IACK instead.
REQ-019 IACK: one cycle, iack=1, irq_id=lowest-index set bit of irq & ie, rfe=10, pc_src=11, pc_we=1, ie cleared; -> FETCH.
REQ-020 DECODE: alu_src_b=11, alu_ctrl=ADD (branch target precompute); next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010/000011 -> JUMP, 010000 -> RFE, other -> FETCH with illegal=1.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, ADD; lw -> MEMRD -> MEMWB (we_reg=1, dm2reg=1, reg_dst=0); sw -> MEMWR (iord=1, we_dm=1).
REQ-022 EXEC decodes funct: 001000 (jr) pc_src=01 style register jump, pc_we=1, -> FETCH; 011001 (multu) mult_start=1 -> MULT; 010000/010010 (mfhi/mflo) -> ALUWB with sf2reg=1, sfmux_high=1 for mfhi; 000000/000010 shifts and ADD/SUB/AND/OR/SLT -> ALUWB; other -> FETCH with illegal=1.
REQ-023 ALUWB: we_reg=1, reg_dst=1, dm2reg=0; -> FETCH.
REQ-024 MULT: 8-bit down-counter loaded with MULT_CYCLES-1 on entry; stays while counter non-zero; -> FETCH when zero; total MULT residency exactly MULT_CYCLES cycles; mult_start high only in the EXEC cycle.
REQ-025 BRANCH: alu_ctrl=SUB, pc_src=01, pc_we=zero; -> FETCH.
REQ-026 JUMP: pc_src=10, pc_we=1; opcode 000011 additionally jal=1, we_reg=1; -> FETCH.
REQ-027 RFE: rfe=01, pc_src=11, pc_we=1, ie set; -> FETCH.
REQ-028 Interrupts are checked only at the FETCH boundary; irq asserted during MULT or any multi-cycle instruction is deferred, never dropped while held.
REQ-029 Simultaneous irq lines: lowest index wins; IACK and RFE never occur back-to-back without an intervening FETCH.
REQ-030 All outputs not listed for a state SHALL be 0 in that state; outputs are decoded from registered state (Moore), except pc_we in BRANCH.

Reset
REQ-031 rst_n low: state=FETCH, ie=1, MULT counter=0, all outputs at FETCH values after release; reset mid-MULT or mid-IACK abandons the operation with no further pulse.

Structure
REQ-032 Opcode, funct, alu_ctrl encodings and state enumeration SHALL live in the shared package ctrl_pkg.
REQ-033 Funct-to-alu_ctrl decode SHALL be one sub-module, ctrl_funct_dec, purely combinational.

Verification
REQ-034 Reset release, opcode=100011 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; we_reg=1 and dm2reg=1 only in cycle 5.
REQ-035 R-type funct=011001, MULT_CYCLES=4 -> mult_start one pulse, exactly 4 MULT cycles, then FETCH.
REQ-036 irq=4'b0110 raised during MULT -> no iack until MULT ends; then IACK with irq_id=1, ie=0, rfe=10.
REQ-037 opcode=000100, zero=0 then zero=1 -> pc_we=0 then pc_we=1 in BRANCH.
REQ-038 opcode=111111 -> illegal=1 one cycle in DECODE, next state FETCH; rst_n pulsed low mid-MULT -> state FETCH, no mult_start.
